// File: rtl/chipmunk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chipmunk_pkg : shared loader state encodings and host status codes   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package chipmunk_pkg;

   localparam logic [3:0] H_ALO  = 4'd0;
   localparam logic [3:0] H_AHI  = 4'd1;
   localparam logic [3:0] H_LLO  = 4'd2;
   localparam logic [3:0] H_LHI  = 4'd3;
   localparam logic [3:0] H_DLO  = 4'd4;
   localparam logic [3:0] H_DHI  = 4'd5;
   localparam logic [3:0] H_DLEN = 4'd6;
   localparam logic [3:0] LOAD   = 4'd7;
   localparam logic [3:0] RUN    = 4'd8;
   localparam logic [3:0] ST     = 4'd9;
   localparam logic [3:0] DUMP   = 4'd10;
   localparam logic [3:0] DRAIN  = 4'd11;

   localparam logic [7:0] ST_OK       = 8'h00;
   localparam logic [7:0] ST_TIMEOUT  = 8'h01;
   localparam logic [7:0] HALT_OPCODE = 8'h83;

endpackage
`default_nettype wire

// File: rtl/chipmunk_tx_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chipmunk_tx_reg : 8-bit valid/ready output register                   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module chipmunk_tx_reg (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] din,
   output logic       can_load,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready
);

   logic       valid_q, valid_d;
   logic [7:0] data_q, data_d;

   always_comb begin
      can_load = !valid_q || tx_ready;
      valid_d  = valid_q;
      data_d   = data_q;
      if (load && can_load) begin
         valid_d = 1'b1;
         data_d  = din;
      end else if (tx_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign tx_valid = valid_q;
   assign tx_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/chipmunk_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chipmunk_loader : host loader, CPU run supervisor and memory dumper   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module chipmunk_loader
   import chipmunk_pkg::*;
#(
   parameter int ADDR_SIZE      = 12,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   output logic                 rx_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 cpu_reset_n,
   output logic [ADDR_SIZE-1:0] cpu_start_pc,
   input  logic [ADDR_SIZE-1:0] cpu_addr,
   input  logic [7:0]           cpu_wdata,
   input  logic                 cpu_we_n,
   input  logic                 cpu_done,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic [7:0]           mem_wdata,
   output logic                 mem_we_n,
   input  logic [7:0]           mem_rdata,
   output logic                 busy
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int HW = ADDR_SIZE - 8;

   logic [3:0]           state_q, state_d;
   logic [ADDR_SIZE-1:0] load_addr_q, load_addr_d;
   logic [ADDR_SIZE-1:0] dump_addr_q, dump_addr_d;
   logic [ADDR_SIZE-1:0] load_ptr_q, load_ptr_d;
   logic [ADDR_SIZE-1:0] dump_ptr_q, dump_ptr_d;
   logic [15:0]          len_q, len_d;
   logic [15:0]          remaining_q, remaining_d;
   logic [7:0]           dump_left_q, dump_left_d;
   logic [7:0]           status_q, status_d;
   logic [CW-1:0]        timer_q, timer_d;
   logic                 cpu_reset_n_q, cpu_reset_n_d;

   logic                 accept;
   logic                 tx_load;
   logic [7:0]           tx_din;
   logic                 tx_can_load;

   always_comb begin
      rx_ready    = reset && (state_q <= LOAD);
      accept      = rx_valid && rx_ready;
      state_d     = state_q;
      load_addr_d = load_addr_q;
      dump_addr_d = dump_addr_q;
      load_ptr_d  = load_ptr_q;
      dump_ptr_d  = dump_ptr_q;
      len_d       = len_q;
      remaining_d = remaining_q;
      dump_left_d = dump_left_q;
      status_d    = status_q;
      timer_d     = '0;
      tx_load     = 1'b0;
      tx_din      = mem_rdata;

      case (state_q)
         H_ALO: if (accept) begin
            load_addr_d[7:0] = rx_data;
            state_d          = H_AHI;
         end
         H_AHI: if (accept) begin
            load_addr_d[ADDR_SIZE-1:8] = rx_data[HW-1:0];
            state_d                    = H_LLO;
         end
         H_LLO: if (accept) begin
            len_d[7:0] = rx_data;
            state_d    = H_LHI;
         end
         H_LHI: if (accept) begin
            len_d[15:8] = rx_data;
            state_d     = H_DLO;
         end
         H_DLO: if (accept) begin
            dump_addr_d[7:0] = rx_data;
            state_d          = H_DHI;
         end
         H_DHI: if (accept) begin
            dump_addr_d[ADDR_SIZE-1:8] = rx_data[HW-1:0];
            state_d                    = H_DLEN;
         end
         H_DLEN: if (accept) begin
            dump_left_d = rx_data;
            load_ptr_d  = load_addr_q;
            dump_ptr_d  = dump_addr_q;
            remaining_d = len_q;
            state_d     = (len_q != 16'd0) ? LOAD : RUN;
         end
         LOAD: if (accept) begin
            load_ptr_d  = load_ptr_q + ADDR_SIZE'(1);
            remaining_d = remaining_q - 16'd1;
            if (remaining_q == 16'd1) state_d = RUN;
         end
         RUN: begin
            timer_d = timer_q + CW'(1);
            // done takes priority when it coincides with the last allowed cycle
            if (cpu_done) begin
               status_d = ST_OK;
               state_d  = ST;
            end else if (timer_q == CW'(TIMEOUT_CYCLES - 1)) begin
               status_d = ST_TIMEOUT;
               state_d  = ST;
            end
         end
         ST: begin
            tx_load = 1'b1;
            tx_din  = status_q;
            if (tx_can_load) state_d = (dump_left_q != 8'd0) ? DUMP : DRAIN;
         end
         DUMP: begin
            tx_load = 1'b1;
            if (tx_can_load) begin
               dump_ptr_d  = dump_ptr_q + ADDR_SIZE'(1);
               dump_left_d = dump_left_q - 8'd1;
               if (dump_left_q == 8'd1) state_d = DRAIN;
            end
         end
         DRAIN: if (!tx_valid || tx_ready) state_d = H_ALO;
         default: state_d = H_ALO;
      endcase

      cpu_reset_n_d = (state_d == RUN);
   end

   // Bus ownership follows the registered state so the mux never glitches
   always_comb begin
      mem_addr  = load_ptr_q;
      mem_wdata = rx_data;
      mem_we_n  = 1'b1;
      case (state_q)
         LOAD: mem_we_n = !(accept && !clk);
         RUN: begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we_n  = cpu_we_n;
         end
         DUMP: mem_addr = dump_ptr_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= H_ALO;
         load_addr_q   <= '0;
         dump_addr_q   <= '0;
         load_ptr_q    <= '0;
         dump_ptr_q    <= '0;
         len_q         <= '0;
         remaining_q   <= '0;
         dump_left_q   <= '0;
         status_q      <= '0;
         timer_q       <= '0;
         cpu_reset_n_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         load_addr_q   <= load_addr_d;
         dump_addr_q   <= dump_addr_d;
         load_ptr_q    <= load_ptr_d;
         dump_ptr_q    <= dump_ptr_d;
         len_q         <= len_d;
         remaining_q   <= remaining_d;
         dump_left_q   <= dump_left_d;
         status_q      <= status_d;
         timer_q       <= timer_d;
         cpu_reset_n_q <= cpu_reset_n_d;
      end
   end

   chipmunk_tx_reg u_tx_reg (
      .clk      (clk),
      .reset    (reset),
      .load     (tx_load),
      .din      (tx_din),
      .can_load (tx_can_load),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   assign cpu_reset_n  = cpu_reset_n_q;
   assign cpu_start_pc = load_addr_q;
   assign busy         = (state_q != H_ALO);

endmodule
`default_nettype wire
